mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Sequencer wrapped around the 4x4 shift-add multiplier (A0-A3, B0-B3, START, READY, P0-P7).
- Upstream side: accepts operand pairs on a valid/ready interface, drives the multiplier's A/B/START and tracks its READY.
- Downstream side: captures the 8-bit product, keeps a running sum, and presents product plus sum on a valid/ready output.

Parameters:
- ACC_W, 16: accumulator width in bits; minimum 8.
- TIMEOUT, 15: maximum cycles spent waiting on mul_READY per operation. Used only with MUL_TIMEOUT_EN.

Ports:
- CK  in  1  clock; all flops on rising edge.
- RN  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid & in_ready.
- in_a  in  4  multiplicand.
- in_b  in  4  multiplier.
- mul_A  out  4  to multiplier A3..A0; registered.
- mul_B  out  4  to multiplier B3..B0; registered.
- mul_START  out  1  to multiplier START; registered one-cycle pulse.
- mul_READY  in  1  from multiplier READY.
- mul_P  in  8  from multiplier P7..P0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_prod  out  8  captured product.
- out_acc  out  ACC_W  running sum of products, including out_prod.
- acc_clr  in  1  synchronous accumulator clear.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (RN low, asynchronous):
  - State goes to IDLE.
  - mul_A, mul_B, mul_START, out_valid, out_prod, out_acc, err, busy and the timeout counter all go to 0.
  - Reset in mid-operation abandons the operation. No output is produced.
- The multiplier is idle when READY=1. Its counter saturates at 7. After START, READY falls on the following edge and returns roughly 8 cycles later.
- in_ready = (state==IDLE) & mul_READY. It is combinational from state and mul_READY.
- State machine:
  - IDLE: on in_valid & in_ready, register in_a into mul_A and in_b into mul_B, set mul_START=1, go to LAUNCH.
  - LAUNCH: mul_START=0 next edge; go to WAIT_LO. mul_A and mul_B stay stable until the next accept, because the multiplier loads them after START.
  - WAIT_LO: stay until mul_READY==0, then go to WAIT_HI. This guards against sampling a stale READY.
  - WAIT_HI: on mul_READY==1, register out_prod<=mul_P and out_acc<=out_acc+mul_P, then go to OUT.
  - OUT: out_valid=1. out_prod and out_acc are held stable while out_valid & !out_ready. On out_ready, clear out_valid and go to IDLE.
- Throughput: at most one operation per (mul latency + 4) cycles. No overlap of operations.
- Accumulator arithmetic:
  - mul_P is zero-extended to ACC_W.
  - The sum wraps modulo 2^ACC_W. There is no saturation and no carry flag.
- acc_clr:
  - In any state, acc_clr clears out_acc to 0 on the next edge.
  - If acc_clr coincides with the WAIT_HI capture, out_acc <= mul_P (clear, then add).
  - If acc_clr arrives during OUT, out_acc changes while out_valid is high. This is permitted and documented; the downstream block samples at the handshake.
- in_valid with !in_ready: the pair is not consumed, and mul_A/mul_B do not change.
- mul_READY held low at reset release: in_ready stays 0 until READY rises.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT_LO and increments every cycle in WAIT_LO and WAIT_HI.
  - When the counter reaches TIMEOUT without a capture, the block sets err=1 (sticky, cleared only by RN) and returns to IDLE.
  - No out_valid is generated, and out_acc is unchanged.
  - While err=1, in_ready is forced to 0.
- Not defined: no counter is built, err is tied to 0, and WAIT_LO/WAIT_HI wait indefinitely.

Test Plan:
- Single op: in_a=3, in_b=5, with a real multiplier model attached, out_ready=1.
  - mul_START is a one-cycle pulse one cycle after accept.
  - out_valid rises after READY returns; out_prod=15, out_acc=15.
- Accumulate: sequence (15,15), (2,7), (0,9) → out_prod 225, 14, 0 and out_acc 225, 239, 239. in_ready=0 throughout each operation.
- Wrap and clear:
  - With ACC_W=8, ops (15,15) then (15,15) → out_acc 225 then 194 (450 mod 256).
  - Then acc_clr asserted in the capture cycle of (1,4) → out_acc=4.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_prod and out_acc stable, in_ready=0, no second mul_START; one cycle of out_ready → IDLE.
- Reset mid-operation: RN pulsed low in WAIT_HI → all outputs 0 immediately, no out_valid. The next op (4,4) yields out_prod=16, out_acc=16.
- Timeout (MUL_TIMEOUT_EN, TIMEOUT=15): mul_READY stuck at 1 after START → err=1 after 15 cycles in WAIT_LO, out_valid never asserts, in_ready=0 until RN.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
//
// Sequencer for an external 4x4 shift-add multiplier. It accepts operand
// pairs on a valid/ready input, launches the multiplier with a registered
// one-cycle START pulse, and waits for READY to go low and then high again.
// It then captures the 8-bit product, adds it to a running accumulator, and
// presents product plus sum on a valid/ready output. Only one operation is in
// flight at a time.
//
// Parameters
//   ACC_W    accumulator width in bits (>= 8); the sum wraps modulo 2^ACC_W
//   TIMEOUT  maximum cycles spent waiting on mul_READY (timeout build only)
//
// Optional feature (compile-time macro MUL_TIMEOUT_EN)
//   defined    a watchdog counts the cycles spent in WAIT_LO/WAIT_HI. On
//              expiry it sets the sticky err flag, abandons the operation,
//              and blocks further input until RN.
//   undefined  no counter is built, err is tied low, and the waits are
//              unbounded.
//
// Ports
//   CK         clock, all flops on the rising edge
//   RN         asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   operand pair accepted when in_valid & in_ready
//   in_a       multiplicand
//   in_b       multiplier
//   mul_A      registered operand A to the multiplier
//   mul_B      registered operand B to the multiplier
//   mul_START  registered one-cycle launch pulse to the multiplier
//   mul_READY  multiplier idle/done flag
//   mul_P      multiplier product
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_prod   captured product
//   out_acc    running sum of products, including out_prod
//   acc_clr    synchronous accumulator clear
//   busy       high whenever the sequencer is not IDLE
//   err        sticky timeout flag (always 0 without MUL_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module mul_seq_ctrl #(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       mul_A,
  output logic [3:0]       mul_B,
  output logic             mul_START,
  input  logic             mul_READY,
  input  logic [7:0]       mul_P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_prod,
  output logic [ACC_W-1:0] out_acc,
  input  logic             acc_clr,
  output logic             busy,
  output logic             err
);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (ACC_W < 8 || TIMEOUT < 1) begin : g_bad_params
    $error("mul_seq_ctrl: ACC_W must be >= 8 and TIMEOUT must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  logic [2:0]       state_q,     state_d;
  logic [3:0]       mul_a_q,     mul_a_d;
  logic [3:0]       mul_b_q,     mul_b_d;
  logic             mul_start_q, mul_start_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_prod_q,  out_prod_d;
  logic [ACC_W-1:0] out_acc_q,   out_acc_d;

  logic accept;    // operand pair handshake this cycle
  logic capture;   // multiplier finished; product is sampled this cycle
  logic tmo_fire;  // watchdog expired without a capture this cycle
  logic err_q;

  // The multiplier result is only trusted after READY has been seen low, so
  // the capture is restricted to WAIT_HI.
  assign capture = (state_q == S_WAIT_HI) && mul_READY;

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef MUL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_d;
  logic             in_wait;

  assign in_wait = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);

  // The counter reaches TIMEOUT on the edge that ends the TIMEOUT-th wait
  // cycle, which is the same edge that raises err and returns to IDLE.
  // A capture in that same cycle takes precedence.
  assign tmo_fire = in_wait && (tmo_cnt_q == TMO_LAST) && !capture;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q | tmo_fire;
    if (state_q == S_LAUNCH) begin
      tmo_cnt_d = '0;
    end else if (in_wait) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  // After a timeout the multiplier is in an unknown condition, so intake
  // stays closed until reset.
  assign in_ready = (state_q == S_IDLE) && mul_READY && !err_q;
`else
  assign tmo_fire = 1'b0;
  assign err_q    = 1'b0;
  assign in_ready = (state_q == S_IDLE) && mul_READY;
`endif

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default at the top. A
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;

    unique case (state_q)
      S_IDLE: begin
        // Operands are registered at accept and then left alone until the
        // next accept, because the multiplier loads them after START.
        if (accept) begin
          mul_a_d     = in_a;
          mul_b_d     = in_b;
          mul_start_d = 1'b1;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        // READY is still high from the previous idle period for one edge
        // after START. Waiting for it to fall avoids sampling a stale READY.
        if (!mul_READY) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (capture) begin
          out_prod_d  = mul_P;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (tmo_fire) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  // A clear that coincides with a capture clears first and then adds, so the
  // sum restarts at the current product. The addition wraps silently. A clear
  // during OUT updates out_acc while out_valid is high; downstream samples
  // at the handshake.
  always_comb begin
    out_acc_d = out_acc_q;
    if (capture) begin
      out_acc_d = (acc_clr ? '0 : out_acc_q) + ACC_W'(mul_P);
    end else if (acc_clr) begin
      out_acc_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q     <= S_IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      out_acc_q   <= '0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
      out_acc_q   <= out_acc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mul_A     = mul_a_q;
  assign mul_B     = mul_b_q;
  assign mul_START = mul_start_q;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign out_acc   = out_acc_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl
//
// Self-checking bench for mul_seq_ctrl with a behavioural multiplier attached.
// Expected (product, sum) pairs are pushed to a scoreboard queue when an
// operand pair is accepted. A monitor pops and compares them at every output
// handshake. ACC_W is 8, so accumulator wrap-around is reachable.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_seq_ctrl;

  localparam int ACC_W   = 8;
  localparam int TIMEOUT = 15;

  logic             CK = 1'b0;
  logic             RN = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_a = '0;
  logic [3:0]       in_b = '0;
  logic [3:0]       mul_A;
  logic [3:0]       mul_B;
  logic             mul_START;
  logic             mul_READY;
  logic [7:0]       mul_P;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_prod;
  logic [ACC_W-1:0] out_acc;
  logic             acc_clr = 1'b0;
  logic             busy;
  logic             err;

  always #5 CK = ~CK;

  mul_seq_ctrl #(.ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .CK        (CK),
    .RN        (RN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_A     (mul_A),
    .mul_B     (mul_B),
    .mul_START (mul_START),
    .mul_READY (mul_READY),
    .mul_P     (mul_P),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_acc   (out_acc),
    .acc_clr   (acc_clr),
    .busy      (busy),
    .err       (err)
  );

  // ---------------------------------------------------------------------------
  // Multiplier model: READY=1 when idle (counter saturated at 7). START
  // restarts the counter, so READY falls on the following edge and returns
  // 7 edges later. m_hold_low and m_stuck override READY.
  // ---------------------------------------------------------------------------
  logic [2:0] m_cnt = 3'd7;
  logic [7:0] m_p = '0;
  logic       m_hold_low = 1'b1;
  logic       m_stuck = 1'b0;

  always @(posedge CK) begin
    if (mul_START) begin
      m_cnt <= 3'd0;
      m_p   <= {4'b0, mul_A} * {4'b0, mul_B};
    end else if (m_cnt != 3'd7) begin
      m_cnt <= m_cnt + 3'd1;
    end
  end

  assign mul_READY = m_hold_low ? 1'b0 : (m_stuck ? 1'b1 : (m_cnt == 3'd7));
  assign mul_P     = m_p;

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0]       prod;
    logic [ACC_W-1:0] acc;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  logic [ACC_W-1:0] acc_model = '0;
  int               total = 0;
  int               bad = 0;
  int               n_out = 0;
  int               n_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Samples 2 ns after the falling edge, after the stimulus has settled and
  // well before the next rising edge.
  always @(negedge CK) begin
    #2;
    if (RN && out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_prod", out_prod, mon_e.prod);
        check("out_acc", out_acc, mon_e.acc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  // Offers (a,b) until it is accepted, then checks the START pulse. It
  // returns at the falling edge after LAUNCH, with a different pair still
  // offered so that operand stability can be checked while busy.
  task automatic launch(input logic [3:0] a, input logic [3:0] b,
                        input bit expect_out, input bit clr_cap);
    int n;
    logic [7:0] p;
    @(negedge CK);
    in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge CK);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    p = {4'b0, a} * {4'b0, b};
    if (expect_out) begin
      acc_model = clr_cap ? ACC_W'(p) : acc_model + ACC_W'(p);
      sb_q.push_back('{prod: p, acc: acc_model});
      n_exp++;
    end
    @(negedge CK);
    in_a = ~a; in_b = ~b;
    check("start_pulse", mul_START, 32'd1);
    check("mul_a", mul_A, a);
    check("mul_b", mul_B, b);
    check("in_ready_busy", in_ready, 32'd0);
    @(negedge CK);
    check("start_fall", mul_START, 32'd0);
  endtask

  // Waits for out_valid while checking the busy-side invariants. It can
  // assert acc_clr in the capture cycle, which is the cycle where READY is
  // back high while the block is still waiting.
  task automatic finish_op(input logic [3:0] a, input logic [3:0] b, input bit clr_cap);
    int n;
    bit clr_done;
    n = 0;
    clr_done = 1'b0;
    while (!out_valid && n < 40) begin
      check("in_ready_wait", in_ready, 32'd0);
      check("busy_wait", busy, 32'd1);
      check("mul_a_hold", mul_A, a);
      check("mul_b_hold", mul_B, b);
      check("start_quiet", mul_START, 32'd0);
      if (clr_cap && !clr_done && mul_READY) begin
        acc_clr = 1'b1;
        clr_done = 1'b1;
      end else begin
        acc_clr = 1'b0;
      end
      @(negedge CK);
      n++;
    end
    acc_clr = 1'b0;
    in_valid = 1'b0;
    check("out_valid_rise", out_valid, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 40) begin
      @(negedge CK);
      n++;
    end
    check("out_valid_fall", out_valid, 32'd0);
    check("busy_idle", busy, 32'd0);
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit clr_cap);
    launch(a, b, 1'b1, clr_cap);
    finish_op(a, b, clr_cap);
    drain();
  endtask

  task automatic clear_acc();
    @(negedge CK);
    acc_clr = 1'b1;
    @(negedge CK);
    acc_clr = 1'b0;
    check("acc_clr_idle", out_acc, 32'd0);
    acc_model = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mul_a"}, mul_A, 32'd0);
    check({tag, "_mul_b"}, mul_B, 32'd0);
    check({tag, "_start"}, mul_START, 32'd0);
    check({tag, "_out_valid"}, out_valid, 32'd0);
    check({tag, "_out_prod"}, out_prod, 32'd0);
    check({tag, "_out_acc"}, out_acc, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_err"}, err, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset with READY held low: outputs cleared, and intake closed until
    // READY rises.
    repeat (3) @(negedge CK);
    check_reset_outputs("reset");
    RN = 1'b1;
    repeat (3) begin
      @(negedge CK);
      check("in_ready_ready_low", in_ready, 32'd0);
    end
    m_hold_low = 1'b0;
    #1;
    check("in_ready_idle", in_ready, 32'd1);

    // Single operation: 3*5.
    do_op(4'd3, 4'd5, 1'b0);

    // Accumulate: 225, 239, 239.
    clear_acc();
    do_op(4'd15, 4'd15, 1'b0);
    do_op(4'd2,  4'd7,  1'b0);
    do_op(4'd0,  4'd9,  1'b0);

    // Wrap at ACC_W=8 (225, then 450 mod 256 = 194), then clear-in-capture.
    clear_acc();
    do_op(4'd15, 4'd15, 1'b0);
    do_op(4'd15, 4'd15, 1'b0);
    do_op(4'd1,  4'd4,  1'b1);

    // Backpressure: hold the result for 10 cycles and offer a new pair.
    out_ready = 1'b0;
    launch(4'd2, 4'd3, 1'b1, 1'b0);
    finish_op(4'd2, 4'd3, 1'b0);
    in_a = 4'd9; in_b = 4'd9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 32'd1);
      check("bp_prod", out_prod, 32'd6);
      check("bp_acc", out_acc, acc_model);
      check("bp_in_ready", in_ready, 32'd0);
      check("bp_no_start", mul_START, 32'd0);
      @(negedge CK);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge CK);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 32'd0);
    check("bp_release_busy", busy, 32'd0);
    out_ready = 1'b1;

    // Reset in WAIT_HI abandons the operation.
    launch(4'd7, 4'd7, 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge CK);
    check("pre_reset_busy", busy, 32'd1);
    RN = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    sb_q.delete();
    n_exp--;
    acc_model = '0;
    @(negedge CK);
    RN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CK);
      check("post_reset_no_valid", out_valid, 32'd0);
    end
    do_op(4'd4, 4'd4, 1'b0);

`ifdef MUL_TIMEOUT_EN
    // READY stuck high after START: err on the edge ending the 15th wait
    // cycle, no output, intake closed until reset.
    m_stuck = 1'b1;
    launch(4'd2, 4'd3, 1'b0, 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge CK);
      check("tmo_err", err, (k == TIMEOUT) ? 32'd1 : 32'd0);
      check("tmo_no_valid", out_valid, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      check("tmo_err_sticky", err, 32'd1);
      check("tmo_in_ready", in_ready, 32'd0);
      check("tmo_busy", busy, 32'd0);
    end
    check("tmo_acc_kept", out_acc, acc_model);
    in_valid = 1'b0;
    m_stuck = 1'b0;
    RN = 1'b0;
    @(negedge CK);
    RN = 1'b1;
    acc_model = '0;
    #1;
    check("tmo_err_cleared", err, 32'd0);
    check("tmo_in_ready_back", in_ready, 32'd1);
`else
    check("err_tied_low", err, 32'd0);
`endif

    repeat (3) @(negedge CK);
    check("out_count", n_out, n_exp);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
